// File: rtl/muldiv_unit_if.sv
// Handshake/data bundle between the EX stage and the iterative multiply/divide unit.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic [1:0]       hilo_we;
    logic [WIDTH-1:0] hilo_wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush, hilo_we, hilo_wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, hilo_we, hilo_wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU engine owning HI/LO, with MTHI/MTLO write path.
// Optional MULDIV_EARLY_OUT_EN: multiplies leave RUN once the remaining multiplier is zero.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);

    localparam int unsigned W2 = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic              neg_q, neg_d;
    logic              neg_rem_q, neg_rem_d;
    logic [W2-1:0]     acc_q, acc_d;
    logic [W2-1:0]     opa_q, opa_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dbz_q, dbz_d;

    logic              op_div, op_signed, a_neg, b_neg, b_zero;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [W2-1:0]     mul_sum, prod_res;
    logic [WIDTH:0]    div_trial;
    logic [WIDTH-1:0]  opb_shift, quo_res, rem_res;
    logic              last_iter;

    // Operand decode: magnitudes and signs for the signed variants.
    always_comb begin
        op_div    = bus.op[1];
        op_signed = ~bus.op[0];
        a_neg     = op_signed & bus.a[WIDTH-1];
        b_neg     = op_signed & bus.b[WIDTH-1];
        a_mag     = a_neg ? -bus.a : bus.a;
        b_mag     = b_neg ? -bus.b : bus.b;
        b_zero    = (bus.b == '0);
    end

    // acc holds the product (multiply) or {remainder, quotient} (divide).
    always_comb begin
        mul_sum   = acc_q + (opb_q[0] ? opa_q : '0);
        div_trial = {acc_q[W2-1:WIDTH], acc_q[WIDTH-1]} - {1'b0, opa_q[WIDTH-1:0]};
        opb_shift = opb_q >> 1;
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
`ifdef MULDIV_EARLY_OUT_EN
        if (!is_div_q && (opb_shift == '0)) begin
            last_iter = 1'b1;
        end
`endif
        prod_res  = neg_q ? -acc_q : acc_q;
        quo_res   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_res   = neg_rem_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        dbz_d     = dbz_q;

        if (!busy_q) begin
            if (bus.hilo_we[1]) hi_d = bus.hilo_wdata;
            if (bus.hilo_we[0]) lo_d = bus.hilo_wdata;
        end

        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    state_d = IDLE;
                    if (bus.start) begin
                        is_div_d  = op_div;
                        neg_d     = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        cnt_d     = '0;
                        opb_d     = b_mag;
                        dbz_d     = op_div & b_zero;
                        if (op_div) begin
                            acc_d = {{WIDTH{1'b0}}, a_mag};
                            opa_d = {{WIDTH{1'b0}}, b_mag};
                        end else begin
                            acc_d = '0;
                            opa_d = {{WIDTH{1'b0}}, a_mag};
                        end
                        // Zero divisor bypasses the datapath; HI/LO keep their value.
                        state_d = (op_div & b_zero) ? DONE : RUN;
                    end
                end
                RUN: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (is_div_q) begin
                        if (!div_trial[WIDTH]) begin
                            acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_d = acc_q << 1;
                        end
                    end else begin
                        acc_d = mul_sum;
                        opa_d = opa_q << 1;
                        opb_d = opb_shift;
                    end
                    if (last_iter) state_d = FIXUP;
                end
                FIXUP: begin
                    if (is_div_q) begin
                        hi_d = rem_res;
                        lo_d = quo_res;
                    end else begin
                        hi_d = prod_res[W2-1:WIDTH];
                        lo_d = prod_res[WIDTH-1:0];
                    end
                    state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == RUN) || (state_d == FIXUP);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            opa_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: cycle-level behavioural model checked every cycle, plus literal anchors.
module tb_muldiv_unit;

    localparam int unsigned W = 32;

    logic clk;
    logic rst;

    muldiv_unit_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // Model: cycle index since acceptance, total latency, pending result, architectural HI/LO.
    int          m_cyc;
    int          m_lat;
    logic [31:0] m_hi, m_lo, m_res_hi, m_res_lo;
    logic        m_dbz;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int mul_latency(input logic [1:0] op, input logic [31:0] b);
        logic [31:0] mag;
        int          bits;
        mag  = (!op[0] && b[31]) ? (~b + 32'd1) : b;
        bits = 0;
        for (int i = 0; i < 32; i++) if (mag[i]) bits = i + 1;
`ifdef MULDIV_EARLY_OUT_EN
        return ((bits < 1) ? 1 : bits) + 2;
`else
        return int'(W) + 2 + (bits - bits);
`endif
    endfunction

    task automatic model_reset();
        m_cyc = 0; m_lat = 0; m_hi = '0; m_lo = '0; m_dbz = 1'b0;
        m_res_hi = '0; m_res_lo = '0;
    endtask

    task automatic model_accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, sq, sr;
        logic [63:0] p, ua, ub;
        m_cyc = 1;
        m_dbz = 1'b0;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op[1]) begin
            if (b == 32'd0) begin
                m_dbz = 1'b1;
                m_lat = 1;
            end else begin
                m_lat = int'(W) + 2;
                if (!op[0]) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    m_res_lo = sq[31:0];
                    m_res_hi = sr[31:0];
                end else begin
                    p = ua / ub;
                    m_res_lo = p[31:0];
                    p = ua % ub;
                    m_res_hi = p[31:0];
                end
            end
        end else begin
            m_lat = mul_latency(op, b);
            if (!op[0]) begin
                sq = sa * sb;
                m_res_hi = sq[63:32];
                m_res_lo = sq[31:0];
            end else begin
                p = ua * ub;
                m_res_hi = p[63:32];
                m_res_lo = p[31:0];
            end
        end
    endtask

    // Advance the model by one clock edge using the inputs the DUT sees at that edge.
    task automatic model_update();
        bit busy_now;
        busy_now = (m_cyc >= 1) && (m_cyc < m_lat);
        if (!busy_now) begin
            if (bus.hilo_we[1]) m_hi = bus.hilo_wdata;
            if (bus.hilo_we[0]) m_lo = bus.hilo_wdata;
        end
        if (bus.flush) begin
            m_cyc = 0;
        end else if (busy_now) begin
            m_cyc++;
            if (m_cyc == m_lat) begin
                m_hi = m_res_hi;
                m_lo = m_res_lo;
            end
        end else if (bus.start) begin
            model_accept(bus.op, bus.a, bus.b);
        end else begin
            m_cyc = 0;
        end
    endtask

    task automatic compare_all();
        chk("busy", bus.busy, 64'((m_cyc >= 1) && (m_cyc < m_lat)));
        chk("done", bus.done, 64'((m_cyc != 0) && (m_cyc == m_lat)));
        chk("div_by_zero", bus.div_by_zero, 64'(m_dbz));
        chk("hi", bus.hi, 64'(m_hi));
        chk("lo", bus.lo, 64'(m_lo));
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        bus.flush = 1'b0; bus.hilo_we = 2'b00; bus.hilo_wdata = '0;
    endtask

    task automatic preload(input logic [31:0] h, input logic [31:0] l);
        bus.hilo_we = 2'b10; bus.hilo_wdata = h; tick();
        bus.hilo_we = 2'b01; bus.hilo_wdata = l; tick();
        bus.hilo_we = 2'b00;
    endtask

    // Issue one op and pin its latency and result with literal expectations.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input int elat,
                          input string name);
        int k, nbusy;
        bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        k = 1; nbusy = 0;
        while (!bus.done && k < 200) begin
            if (bus.busy) nbusy++;
            tick();
            k++;
        end
        if (elat > 0) begin
            chk({name, "_latency"}, 64'(k), 64'(elat));
            chk({name, "_busy_cycles"}, 64'(nbusy), 64'(elat - 1));
        end
        chk({name, "_hi"}, bus.hi, 64'(eh));
        chk({name, "_lo"}, bus.lo, 64'(el));
        tick();
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 6))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'($urandom_range(0, 15));
            5: return -32'($urandom_range(1, 15));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit saw_done;
        checks = 0;
        errors = 0;
        model_reset();
        idle_inputs();
        rst = 1'b1;
        #12;
        chk("reset_busy", bus.busy, 64'd0);
        chk("reset_done", bus.done, 64'd0);
        chk("reset_dbz", bus.div_by_zero, 64'd0);
        chk("reset_hi", bus.hi, 64'd0);
        chk("reset_lo", bus.lo, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34, "multu_max");
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, -1, "mult_neg3x7");
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 34, "mult_minxmin");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, "div_neg7by2");
        run_op(2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 34, "divu_7by2");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 34, "div_min_by_m1");

        preload(32'h11, 32'h22);
        run_op(2'b10, 32'd1234, 32'd0, 32'h11, 32'h22, 1, "div_by_zero");
        chk("dbz_flag_held", bus.div_by_zero, 64'd1);

`ifdef MULDIV_EARLY_OUT_EN
        run_op(2'b01, 32'd5, 32'd1, 32'd0, 32'd5, 3, "multu_early");
`else
        run_op(2'b01, 32'd5, 32'd1, 32'd0, 32'd5, 34, "multu_early");
`endif

        // Ignored start, ignored HI/LO write and a flush while an op is in flight.
        preload(32'hAAAA_5555, 32'h0F0F_0F0F);
        bus.op = 2'b01; bus.a = 32'h1234; bus.b = 32'h5678; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        saw_done = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (bus.done) saw_done = 1'b1;
            if (cyc == 10) chk("busy_before_flush", bus.busy, 64'd1);
            if (cyc == 11) begin
                chk("flush_busy", bus.busy, 64'd0);
                chk("flush_hi", bus.hi, 64'hAAAA_5555);
                chk("flush_lo", bus.lo, 64'h0F0F_0F0F);
            end
            bus.start = 1'b0; bus.flush = 1'b0; bus.hilo_we = 2'b00;
            if (cyc == 5) begin
                bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd100; bus.b = 32'd7;
            end
            if (cyc == 7) begin
                bus.hilo_we = 2'b11; bus.hilo_wdata = 32'hDEAD_BEEF;
            end
            if (cyc == 10) bus.flush = 1'b1;
            tick();
        end
        chk("flush_no_done", 64'(saw_done), 64'd0);

        // Asynchronous reset in the middle of RUN, between clock edges.
        bus.op = 2'b01; bus.a = 32'hFFFF_FFFF; bus.b = 32'hFFFF_FFFF; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", bus.busy, 64'd0);
        chk("rst_mid_done", bus.done, 64'd0);
        chk("rst_mid_dbz", bus.div_by_zero, 64'd0);
        chk("rst_mid_hi", bus.hi, 64'd0);
        chk("rst_mid_lo", bus.lo, 64'd0);
        model_reset();
        #1;
        rst = 1'b0;
        tick();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            bus.start      = ($urandom_range(0, 3) == 0);
            bus.op         = 2'($urandom_range(0, 3));
            bus.a          = pick_operand();
            bus.b          = pick_operand();
            bus.flush      = ($urandom_range(0, 49) == 0);
            bus.hilo_we    = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            bus.hilo_wdata = $urandom;
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 40; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide engine in EX. Executes MULT, MULTU, DIV and DIVU, the instructions the decoder tags with RegDst = PROD.
- Owns the HI/LO registers and provides a direct write path for MTHI and MTLO.
- Holds a busy handshake so the hazard logic can stall MFHI/MFLO and any new mul/div until the result is ready.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- start  in  1  request a new operation; sampled at a clock edge
- op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- a  in  WIDTH  GPR[rs]; multiplicand or dividend
- b  in  WIDTH  GPR[rt]; multiplier or divisor
- flush  in  1  abort the in-flight operation (exception or ERET)
- hilo_we  in  2  bit1 writes HI, bit0 writes LO (MTHI/MTLO)
- hilo_wdata  in  WIDTH  data for hilo_we
- busy  out  1  operation in flight
- done  out  1  one-cycle pulse: HI/LO updated this cycle
- div_by_zero  out  1  last accepted division had b == 0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (asynchronous, rst = 1): state IDLE, counter 0. All outputs 0: hi, lo, busy, done, div_by_zero.
- FSM states: IDLE, RUN, FIXUP, DONE.
  - busy = (state == RUN or FIXUP).
  - done = (state == DONE).
- Accepting start:
  - start is accepted only in IDLE or DONE, and only when flush = 0.
  - On acceptance, latch op, |a| and |b| (magnitude only for MULT/DIV), and the result sign bits; clear div_by_zero; go to RUN.
  - start while busy is ignored; no queueing.
- RUN: exactly WIDTH cycles of radix-2 iteration.
  - Multiply: shift-add over a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract producing WIDTH quotient bits.
  - After iteration WIDTH, go to FIXUP.
- FIXUP, one cycle:
  - Apply two's-complement negation where the sign rules require it.
  - Write {hi,lo} = product for MULT/MULTU.
  - Write lo = quotient, hi = remainder for DIV/DIVU.
  - Go to DONE.
- DONE, one cycle: done = 1; returns to IDLE unless a new start is accepted.
- Latency: for a start accepted at edge 0, done is high in cycle WIDTH+2 and the new hi/lo are visible in that cycle.
- Signed arithmetic rules:
  - Product is the full 2*WIDTH signed product.
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Most-negative / -1 gives lo = 2^(WIDTH-1) and hi = 0, with no trap.
- Divide by zero (DIV/DIVU with b == 0):
  - Skip RUN and FIXUP: the next state is DONE, so done is high in cycle 1.
  - hi and lo are unchanged; div_by_zero = 1, held until the next accepted start.
- flush:
  - Synchronous, highest priority after rst; next state is IDLE.
  - No done pulse; hi and lo are unchanged; a start in the same cycle is ignored.
- hilo_we:
  - Applied at the edge only when busy = 0.
  - Ignored while busy; the hazard unit guarantees it is not issued then.
  - If asserted together with an accepted start, the write is applied and the later result overwrites it.
- The FIXUP write takes priority over hilo_we; both cannot occur because busy = 1 during FIXUP.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- When defined, for MULT/MULTU, RUN exits to FIXUP as soon as the remaining unshifted multiplier magnitude is zero.
  - If b == 0 or the magnitude of b is 1, RUN lasts 1 cycle and done is high in cycle 3.
  - Latency ranges from 3 to WIDTH+2 cycles.
- Divide latency is unchanged.
- When not defined, all non-zero-divisor operations take exactly WIDTH+2 cycles.

Test Plan:
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> done in cycle 34 with hi=0xFFFFFFFE, lo=0x00000001; busy high in cycles 1-33.
- MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21); MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=7, b=2 -> lo=3, hi=1; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV b=0 with preloaded hi=0x11, lo=0x22 -> done in cycle 1, div_by_zero=1, hi=0x11 and lo=0x22 unchanged.
- Mid-operation events:
  - start in cycle 5 is ignored.
  - flush in cycle 10 -> busy=0 in cycle 11, no done, hi/lo unchanged.
  - hilo_we=11 while busy is ignored.
- Reset and early-out:
  - rst pulsed mid-RUN between edges -> all outputs 0 immediately.
  - With MULDIV_EARLY_OUT_EN, MULTU a=5, b=1 -> done in cycle 3, lo=5.
